// File: rtl/pri_rv32_lsu.sv
// Load/store unit: takes one execute-stage memory request, runs it on a single-port
// valid/ready data bus, and returns extended load data to writeback.
module pri_rv32_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_is_store_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              busy_o,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // initiator holds its payload stable from valid until that edge.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_is_store;
    logic [4:0]        r_rd;
    logic [31:0]       r_wdata;
    logic [CW-1:0]     r_tcnt;
    logic              r_misalign;
    logic              r_bus_err;
    logic [31:0]       r_wb_data;
    logic [4:0]        r_wb_rd;

    logic              w_accept;
    logic              w_illegal;
    logic              w_tcnt_last;
    logic [1:0]        w_off;
    logic [31:0]       w_shift;
    logic [31:0]       w_load_data;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata_rep;

    assign w_accept  = req_valid_i && (r_state == S_IDLE);
    assign w_illegal = (req_size_i == 2'b11) ||
                       ((req_size_i == 2'b01) && req_addr_i[0]) ||
                       ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
    assign w_tcnt_last = (TIMEOUT_CYCLES != 0) &&
                         ({{(32-CW){1'b0}}, r_tcnt} == (TIMEOUT_CYCLES - 32'd1));
    assign w_off = r_addr[1:0];

    always_comb begin
        w_wdata_rep = req_wdata_i;
        case (req_size_i)
            2'b00:   w_wdata_rep = {4{req_wdata_i[7:0]}};
            2'b01:   w_wdata_rep = {2{req_wdata_i[15:0]}};
            default: w_wdata_rep = req_wdata_i;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b0000;
        if (r_is_store) begin
            case (r_size)
                2'b00:   w_wstrb = 4'b0001 << w_off;
                2'b01:   w_wstrb = 4'b0011 << w_off;
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    // Bring the addressed lane down to bit 0, then extend from the access width.
    assign w_shift = mem_rdata_i >> {w_off, 3'b000};
    always_comb begin
        w_load_data = w_shift;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'd0, w_shift[7:0]}
                                              : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load_data = r_unsigned ? {16'd0, w_shift[15:0]}
                                              : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && !w_illegal) w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                // A ready arriving on the terminal count still completes normally.
                if (mem_ready_i)      w_state_nxt = r_is_store ? S_IDLE : S_RESP;
                else if (w_tcnt_last) w_state_nxt = S_IDLE;
            end
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_is_store <= 1'b0;
            r_rd       <= 5'd0;
            r_wdata    <= 32'd0;
            r_tcnt     <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_rd    <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_accept && w_illegal;
            r_bus_err  <= (r_state == S_ACCESS) && !mem_ready_i && w_tcnt_last;
            if (w_accept && !w_illegal) begin
                r_addr     <= req_addr_i;
                r_size     <= req_size_i;
                r_unsigned <= req_unsigned_i;
                r_is_store <= req_is_store_i;
                r_rd       <= req_rd_i;
                r_wdata    <= w_wdata_rep;
                r_tcnt     <= '0;
            end else if ((r_state == S_ACCESS) && !mem_ready_i) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if ((r_state == S_ACCESS) && mem_ready_i && !r_is_store) begin
                r_wb_data <= w_load_data;
                r_wb_rd   <= r_rd;
            end
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign mem_valid_o = (r_state == S_ACCESS);
    assign mem_we_o    = r_is_store && (r_state == S_ACCESS);
    assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wstrb_o = w_wstrb;
    assign mem_wdata_o = r_wdata;
    assign wb_valid_o  = (r_state == S_RESP);
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign misalign_o  = r_misalign;
    assign bus_err_o   = r_bus_err;
    assign busy_o      = (r_state != S_IDLE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pri_rv32_lsu.sv
// Directed bench for pri_rv32_lsu: loads, stores, misalignment, timeout and async reset.
module tb_pri_rv32_lsu;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_is_store_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        busy_o;
    logic [1:0]  dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;

    pri_rv32_lsu #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_is_store_i(req_is_store_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .busy_o(busy_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    // Driver: present a request in the current (idle) cycle, return in cycle T+1.
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i    = 1'b1;
        req_is_store_i = st;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wd;
        req_rd_i       = rd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %0b want 1", req_ready_o); end
        n_cmp++; if ({mem_valid_o, mem_we_o, wb_valid_o, misalign_o, bus_err_o, busy_o} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 000000", {mem_valid_o, mem_we_o, wb_valid_o, misalign_o, bus_err_o, busy_o}); end
        n_cmp++; if ({mem_addr_o, mem_wstrb_o, mem_wdata_o, wb_data_o, wb_rd_o} !== '0) begin
            n_err++; $display("FAIL reset_data got addr=%h strb=%b wd=%h wb=%h rd=%0d want all 0",
                              mem_addr_o, mem_wstrb_o, mem_wdata_o, wb_data_o, wb_rd_o); end
        @(negedge clk_i); rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_byte();
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd5);
        n_cmp++; if (mem_valid_o !== 1'b1) begin n_err++; $display("FAIL lb_mem_valid got %0b want 1", mem_valid_o); end
        n_cmp++; if (mem_addr_o !== 32'h100) begin n_err++; $display("FAIL lb_mem_addr got %h want 00000100", mem_addr_o); end
        n_cmp++; if (mem_wstrb_o !== 4'b0000 || mem_we_o !== 1'b0) begin n_err++; $display("FAIL lb_strb got %b we=%0b want 0000 we=0", mem_wstrb_o, mem_we_o); end
        n_cmp++; if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL lb_busy got rdy=%0b busy=%0b want 0 1", req_ready_o, busy_o); end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h80AABBCC;
        next_cycle();
        mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL lb_wb_valid got %0b want 1", wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_wb_data got %h want ffffff80", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd5) begin n_err++; $display("FAIL lb_wb_rd got %0d want 5", wb_rd_o); end
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL lb_mem_drop got %0b want 0", mem_valid_o); end
        next_cycle();
        n_cmp++; if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin n_err++; $display("FAIL lb_t3 got rdy=%0b wbv=%0b want 1 0", req_ready_o, wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_hold got %h want ffffff80", wb_data_o); end
    endtask

    task automatic test_load_half();
        issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 5'd7);
        mem_ready_i = 1'b1; mem_rdata_i = 32'h80011234;
        next_cycle();
        mem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h00008001) begin n_err++; $display("FAIL lhu_data got v=%0b %h want 1 00008001", wb_valid_o, wb_data_o); end
        next_cycle();
        issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd8);
        mem_ready_i = 1'b1; mem_rdata_i = 32'h80011234;
        next_cycle();
        mem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_data got v=%0b %h want 1 ffff8001", wb_valid_o, wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd8) begin n_err++; $display("FAIL lh_rd got %0d want 8", wb_rd_o); end
        next_cycle();
    endtask

    task automatic test_load_wait();
        // lbu at offset 1 with one memory wait cycle; bus outputs must hold.
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0, 5'd3);
        next_cycle();
        n_cmp++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h40) begin n_err++; $display("FAIL lbu_wait_hold got v=%0b a=%h want 1 00000040", mem_valid_o, mem_addr_o); end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h1234F0AA;
        next_cycle();
        mem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h000000F0) begin n_err++; $display("FAIL lbu_data got v=%0b %h want 1 000000f0", wb_valid_o, wb_data_o); end
        next_cycle();
    endtask

    task automatic test_store();
        issue(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 5'd0);
        n_cmp++; if (mem_valid_o !== 1'b1 || mem_we_o !== 1'b1) begin n_err++; $display("FAIL sb_ctrl got v=%0b we=%0b want 1 1", mem_valid_o, mem_we_o); end
        n_cmp++; if (mem_wstrb_o !== 4'b0010) begin n_err++; $display("FAIL sb_strb got %b want 0010", mem_wstrb_o); end
        n_cmp++; if (mem_wdata_o !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wdata got %h want a5a5a5a5", mem_wdata_o); end
        n_cmp++; if (mem_addr_o !== 32'h300) begin n_err++; $display("FAIL sb_addr got %h want 00000300", mem_addr_o); end
        mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
        n_cmp++; if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0 || mem_valid_o !== 1'b0) begin
            n_err++; $display("FAIL sb_t2 got rdy=%0b wbv=%0b mv=%0b want 1 0 0", req_ready_o, wb_valid_o, mem_valid_o); end
        // Back-to-back: sh issued in the very cycle the unit is ready again.
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 5'd0);
        n_cmp++; if (mem_wstrb_o !== 4'b1100 || mem_wdata_o !== 32'hABCDABCD) begin n_err++; $display("FAIL sh_lanes got %b %h want 1100 abcdabcd", mem_wstrb_o, mem_wdata_o); end
        mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        n_cmp++; if (mem_wstrb_o !== 4'b1111 || mem_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_lanes got %b %h want 1111 deadbeef", mem_wstrb_o, mem_wdata_o); end
        mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
    endtask

    task automatic test_misalign();
        logic [1:0]  sz_t [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad_t [3] = '{32'h402, 32'h403, 32'h400};
        logic        st_t [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            issue(st_t[i], sz_t[i], 1'b0, ad_t[i], 32'h0, 5'd1);
            n_cmp++; if (misalign_o !== 1'b1 || mem_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                n_err++; $display("FAIL misalign_%0d got mis=%0b mv=%0b rdy=%0b want 1 0 1", i, misalign_o, mem_valid_o, req_ready_o); end
            next_cycle();
            n_cmp++; if (misalign_o !== 1'b0 || wb_valid_o !== 1'b0) begin
                n_err++; $display("FAIL misalign_pulse_%0d got mis=%0b wbv=%0b want 0 0", i, misalign_o, wb_valid_o); end
        end
    endtask

    task automatic test_timeout();
        int vcnt;
        vcnt = 0;
        issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd9);
        for (int k = 0; k < 4; k++) begin
            if (mem_valid_o === 1'b1) vcnt++;
            next_cycle();
        end
        n_cmp++; if (vcnt != 4) begin n_err++; $display("FAIL to_valid_cycles got %0d want 4", vcnt); end
        n_cmp++; if (mem_valid_o !== 1'b0 || bus_err_o !== 1'b1 || wb_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_err++; $display("FAIL to_err got mv=%0b err=%0b wbv=%0b rdy=%0b want 0 1 0 1", mem_valid_o, bus_err_o, wb_valid_o, req_ready_o); end
        n_cmp++; if (wb_data_o !== 32'h000000F0) begin n_err++; $display("FAIL to_wb_hold got %h want 000000f0", wb_data_o); end
        next_cycle();
        n_cmp++; if (bus_err_o !== 1'b0) begin n_err++; $display("FAIL to_err_pulse got %0b want 0", bus_err_o); end
        // Ready arriving on the terminal cycle completes the load.
        issue(1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 5'd10);
        next_cycle(); next_cycle(); next_cycle();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h13572468;
        next_cycle();
        mem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1 || bus_err_o !== 1'b0 || wb_data_o !== 32'h13572468) begin
            n_err++; $display("FAIL to_late_ready got wbv=%0b err=%0b d=%h want 1 0 13572468", wb_valid_o, bus_err_o, wb_data_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd2);
        n_cmp++; if (mem_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got %0b want 1", mem_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_err++; $display("FAIL rst_mid got mv=%0b busy=%0b rdy=%0b want 0 0 1", mem_valid_o, busy_o, req_ready_o); end
        #1 rst_n = 1'b1;
        next_cycle();
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd2);
        mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        next_cycle();
        mem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hCAFEF00D || wb_rd_o !== 5'd2) begin
            n_err++; $display("FAIL rst_after got v=%0b d=%h rd=%0d want 1 cafef00d 2", wb_valid_o, wb_data_o, wb_rd_o); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_load_wait();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pri_rv32_lsu.md
Name: pri_rv32_lsu

Overview:
Load/store unit sitting directly downstream of the execute stage. Accepts one memory request per transaction: execute-computed address, size, sign mode, store data and destination register. Drives a single-port data-memory bus with a valid/ready handshake, generates byte strobes and lane-replicated store data, and returns sign/zero-extended load results to writeback. Detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in ACCESS waiting for mem_ready_i; 0 disables the timeout
ADDR_W, 32, address width (bits above 1:0 pass through unchanged)

Ports:
clk_i  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  execute stage presents a memory request
req_ready_o  output  1  LSU can accept a request this cycle
req_is_store_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned_i  input  1  load zero-extends (lbu/lhu); ignored for stores
req_addr_i  input  ADDR_W  byte address (rs1 + imm)
req_wdata_i  input  32  store data (rs2)
req_rd_i  input  5  load destination register
mem_valid_o  output  1  bus request active
mem_ready_i  input  1  memory completes the transfer this cycle; read data is valid in the same cycle
mem_we_o  output  1  write enable
mem_addr_o  output  ADDR_W  word-aligned address (bits 1:0 forced to 0)
mem_wstrb_o  output  4  byte strobes
mem_wdata_o  output  32  lane-replicated store data
mem_rdata_i  input  32  read data
wb_valid_o  output  1  one-cycle load result pulse
wb_rd_o  output  5  load destination register
wb_data_o  output  32  extended load data
misalign_o  output  1  one-cycle pulse: misaligned access or reserved size
bus_err_o  output  1  one-cycle pulse: timeout
busy_o  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate): state IDLE, timeout counter 0, every output 0 except req_ready_o = 1. An in-flight bus request is dropped; mem_valid_o falls without waiting for a clock edge.
- States are IDLE, ACCESS and RESP. req_ready_o = 1 only in IDLE. A request is accepted on a rising edge where req_valid_i && req_ready_o.
- Alignment check at acceptance:
  - half with addr[0] = 1 is illegal.
  - word with addr[1:0] != 0 is illegal.
  - size 11 is illegal.
  - Illegal request: no bus access. misalign_o = 1 for exactly the next cycle. State stays IDLE. No wb_valid_o.
- Legal request: latch address, size, unsigned, rd and is_store, then go to ACCESS. In ACCESS:
  - mem_valid_o = 1.
  - mem_addr_o, mem_we_o, mem_wstrb_o and mem_wdata_o are held stable until mem_ready_i.
- Strobes (off = addr[1:0]):
  - byte: 0001 << off
  - half: 0011 << off
  - word: 1111
  - loads: 0000
- Store data: byte replicated as {4{d[7:0]}}; half as {2{d[15:0]}}; word unchanged.
- ACCESS with mem_ready_i = 1:
  - store: go to IDLE.
  - load: shift mem_rdata_i right by 8*off, extend from bit 7 (byte) or bit 15 (half), sign or zero per the latched unsigned flag, register into wb_data_o, go to RESP.
- RESP: wb_valid_o = 1 for one cycle, then IDLE. wb_rd_o and wb_data_o hold their values until the next load response.
- Latency (request accepted at edge T, ready returned first cycle):
  - mem_valid_o high in cycle T+1.
  - load: wb_valid_o high in cycle T+2; req_ready_o high again in cycle T+3.
  - store: req_ready_o high again in cycle T+2.
  - Each memory wait cycle adds 1.
- Timeout: the counter clears on entering ACCESS and increments every ACCESS cycle without mem_ready_i. When it reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0):
  - deassert mem_valid_o and go to IDLE.
  - bus_err_o = 1 for one cycle; no writeback.
  - mem_ready_i arriving in the same cycle as the terminal count wins: the transfer completes normally and there is no error.
- req_valid_i while busy is ignored; the upstream holds its request until req_ready_o.

Test Plan:
- lb from addr 0x103, rdata 0x80AABBCC -> mem_addr_o 0x100, strobes 0000, wb_data_o 0xFFFFFF80, wb_valid_o at T+2.
- lhu from addr 0x202, rdata 0x8001_1234 -> wb_data_o 0x00008001; lh from the same address -> 0xFFFF8001.
- sb data 0x000000A5 at addr 0x301 -> mem_wstrb_o 0010, mem_wdata_o 0xA5A5A5A5, mem_we_o 1, no wb_valid_o, req_ready_o back at T+2.
- lw at addr 0x402 and sh at 0x403 -> misalign_o pulse one cycle after acceptance, mem_valid_o stays 0, req_ready_o stays 1.
- TIMEOUT_CYCLES = 4 with mem_ready_i held 0 -> mem_valid_o high for 4 cycles, then drops with a bus_err_o pulse; repeat with ready on the 4th cycle -> normal completion, no error.
- Assert rst_n low mid-ACCESS -> mem_valid_o low immediately, busy_o 0, req_ready_o 1; the next request after reset completes normally.
